// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatter (byte/half/word, sign/zero extend).
// Optional retire counter port enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [5:0]        in_opcode,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_regwrite,
   input  logic              in_memtoreg,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_misalign
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       retire_count
`endif
);

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;

   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] next_data;
   logic              misaligned;
   logic              next_regwrite;

   // Little-endian lane pick; lane widths assume a 32-bit datapath.
   always_comb begin
      byte_sel = in_mem_data[7:0];
      case (in_alu_result[1:0])
         2'd0: byte_sel = in_mem_data[7:0];
         2'd1: byte_sel = in_mem_data[15:8];
         2'd2: byte_sel = in_mem_data[23:16];
         2'd3: byte_sel = in_mem_data[31:24];
         default: byte_sel = in_mem_data[7:0];
      endcase
      half_sel = in_alu_result[1] ? in_mem_data[31:16] : in_mem_data[15:0];
   end

   always_comb begin
      load_data  = in_mem_data;
      misaligned = 1'b0;
      case (in_opcode)
         OP_LW: begin
            load_data  = in_mem_data;
            misaligned = (in_alu_result[1:0] != 2'b00);
         end
         OP_LH: begin
            load_data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
            misaligned = in_alu_result[0];
         end
         OP_LHU: begin
            load_data  = {{(DATA_W-16){1'b0}}, half_sel};
            misaligned = in_alu_result[0];
         end
         OP_LB:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         OP_LBU: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         default: load_data = in_mem_data;
      endcase
      // Alignment only matters when the slot actually writes back from memory.
      misaligned    = misaligned & in_valid & in_memtoreg;
      next_data     = in_memtoreg ? load_data : in_alu_result;
      next_regwrite = in_valid & in_regwrite & (in_rd != '0) & ~misaligned;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_misalign <= 1'b0;
      end else if (flush) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_misalign <= 1'b0;
      end else if (stall) begin
         // Hold the slot but never repeat the misalign pulse.
         wb_misalign <= 1'b0;
      end else begin
         wb_valid    <= in_valid;
         wb_regwrite <= next_regwrite;
         wb_rd       <= in_rd;
         wb_data     <= next_data;
         wb_misalign <= misaligned;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_count <= '0;
      else if (!flush && !stall && in_valid)
         retire_count <= retire_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases plus randomized traffic vs a behavioural model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, in_valid, in_regwrite, in_memtoreg;
   logic [5:0]  in_opcode;
   logic [31:0] in_alu_result, in_mem_data;
   logic [4:0]  in_rd;
   logic        wb_valid, wb_regwrite, wb_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_opcode(in_opcode), .in_alu_result(in_alu_result),
      .in_mem_data(in_mem_data), .in_rd(in_rd), .in_regwrite(in_regwrite),
      .in_memtoreg(in_memtoreg), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign)
`ifdef WB_RETIRE_CNT_EN
      , .retire_count(retire_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] d;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t model;
   exp_t q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_load(logic [5:0] op);
      return op == 6'b100011 || op == 6'b100001 || op == 6'b100101 ||
             op == 6'b100000 || op == 6'b100100;
   endfunction

   // Reference formatting: shift the addressed lane down, then extend.
   function automatic logic [31:0] fmt(logic [5:0] op, logic [31:0] addr, logic [31:0] mem);
      logic [31:0]        sh;
      logic signed [7:0]  sb;
      logic signed [15:0] sh16;
      sh   = mem >> (8 * (addr % 4));
      sb   = sh[7:0];
      sh16 = 16'(mem >> (16 * ((addr / 2) % 2)));
      case (op)
         6'b100011: return mem;
         6'b100001: return int'(sh16);
         6'b100101: return {16'h0, sh16};
         6'b100000: return int'(sb);
         6'b100100: return {24'h0, sb};
         default:   return mem;
      endcase
   endfunction

   function automatic bit misfit(logic [5:0] op, logic [31:0] addr);
      if (op == 6'b100011) return (addr % 4) != 0;
      if (op == 6'b100001 || op == 6'b100101) return (addr % 2) != 0;
      return 1'b0;
   endfunction

   task automatic drive(bit st, bit fl, bit v, logic [5:0] op, logic [31:0] alu,
                        logic [31:0] mem, logic [4:0] rd, bit rw, bit m2r);
      bit mis;
      stall = st; flush = fl; in_valid = v; in_opcode = op; in_alu_result = alu;
      in_mem_data = mem; in_rd = rd; in_regwrite = rw; in_memtoreg = m2r;
      if (!fl && !st && v) model.cnt = model.cnt + 1;
      if (fl) begin
         model.v = 0; model.rw = 0; model.rd = 0; model.d = 0; model.mis = 0;
      end else if (st) begin
         model.mis = 0;
      end else begin
         mis       = v && m2r && misfit(op, alu);
         model.v   = v;
         model.mis = mis;
         model.rw  = v && rw && rd != 0 && !mis;
         model.rd  = rd;
         model.d   = m2r ? fmt(op, alu, mem) : alu;
      end
      q.push_back(model);
   endtask

   task automatic step(bit st, bit fl, bit v, logic [5:0] op, logic [31:0] alu,
                       logic [31:0] mem, logic [4:0] rd, bit rw, bit m2r);
      @(negedge clk);
      drive(st, fl, v, op, alu, mem, rd, rw, m2r);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         chk("wb_valid", {31'h0, wb_valid}, {31'h0, e.v});
         chk("wb_regwrite", {31'h0, wb_regwrite}, {31'h0, e.rw});
         chk("wb_misalign", {31'h0, wb_misalign}, {31'h0, e.mis});
         // rd/data are defined only for live slots and for bubbles (driven 0).
         if (e.v || e.d == 0) begin
            chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
            chk("wb_data", wb_data, e.d);
         end
`ifdef WB_RETIRE_CNT_EN
         chk("retire_count", retire_count, e.cnt);
`endif
      end
   end

   task automatic check_zero_outputs(string tag);
      chk({tag, "_valid"}, {31'h0, wb_valid}, 32'h0);
      chk({tag, "_regwrite"}, {31'h0, wb_regwrite}, 32'h0);
      chk({tag, "_rd"}, {27'h0, wb_rd}, 32'h0);
      chk({tag, "_data"}, wb_data, 32'h0);
      chk({tag, "_misalign"}, {31'h0, wb_misalign}, 32'h0);
`ifdef WB_RETIRE_CNT_EN
      chk({tag, "_count"}, retire_count, 32'h0);
`endif
   endtask

   task automatic rand_step();
      logic [5:0] op;
      bit m2r;
      case ($urandom_range(0, 6))
         0: op = 6'b100011;
         1: op = 6'b100001;
         2: op = 6'b100101;
         3: op = 6'b100000;
         4: op = 6'b100100;
         default: op = 6'($urandom);
      endcase
      m2r = is_load(op) ? 1'b1 : 1'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           op, $urandom, $urandom, 5'($urandom), 1'($urandom), m2r);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      model = '0;
      rst_n = 1'b0;
      stall = 0; flush = 0; in_valid = 0; in_opcode = 0; in_alu_result = 0;
      in_mem_data = 0; in_rd = 0; in_regwrite = 0; in_memtoreg = 0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;

      step(0, 0, 1, 6'b100011, 32'h04, 32'hDEADBEEF, 5'd5, 1, 1);
      step(0, 0, 1, 6'b100000, 32'h0B, 32'h80FF7F01, 5'd6, 1, 1);
      step(0, 0, 1, 6'b100100, 32'h0B, 32'h80FF7F01, 5'd6, 1, 1);
      step(0, 0, 1, 6'b100001, 32'h0A, 32'h80FF7F01, 5'd7, 1, 1);
      step(0, 0, 1, 6'b100101, 32'h0A, 32'h80FF7F01, 5'd7, 1, 1);
      step(0, 0, 1, 6'b100011, 32'h06, 32'h12345678, 5'd8, 1, 1);
      step(0, 0, 1, 6'b000000, 32'h00001234, 32'h0, 5'd0, 1, 0);
      step(0, 0, 1, 6'b100001, 32'h03, 32'hAAAA5555, 5'd9, 1, 1);
      repeat (3) step(1, 0, 1, 6'b000000, 32'h5555, 32'h0, 5'd3, 1, 0);
      step(0, 0, 1, 6'b000000, 32'h00000077, 32'h0, 5'd4, 1, 0);
      repeat (3) step(1, 0, 1, 6'b100011, 32'h0, 32'h1, 5'd1, 1, 1);
      step(1, 1, 1, 6'b100011, 32'h0, 32'h1, 5'd1, 1, 1);
      step(0, 0, 0, 6'b100011, 32'h2, 32'h1, 5'd1, 1, 1);
      step(0, 0, 1, 6'b111111, 32'h2, 32'hCAFEF00D, 5'd31, 1, 1);

      repeat (3000) rand_step();

      // Asynchronous reset asserted between edges must clear outputs at once.
      step(0, 0, 1, 6'b000000, 32'hFFFF0001, 32'h0, 5'd12, 1, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      model = '0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (500) rand_step();

      @(negedge clk);
      stall = 1;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
